// File: rtl/mm2s_cmd_engine.sv
// MM2S command engine: splits one DataMover-style read command into 4KB-safe AXI4 INCR
// bursts, forwards read beats as a stream, then reports one status byte per command.
module mm2s_cmd_engine #(
    parameter int unsigned MAX_BURST = 16,
    parameter logic [3:0]  ARID      = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_axis_cmd_tvalid,
    output logic        s_axis_cmd_tready,
    input  logic [71:0] s_axis_cmd_tdata,
    output logic [3:0]  m_axi_arid,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [7:0]  m_axis_sts_tdata,
    output logic        m_axis_sts_tvalid,
    output logic        m_axis_sts_tkeep,
    output logic        m_axis_sts_tlast,
    input  logic        m_axis_sts_tready,
    output logic [1:0]  dbg_state
);

    // Every channel is valid/ready: a transfer occurs on a rising edge with both high,
    // and the source holds valid and payload stable until that edge.
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, STS = 2'd3} state_t;

    state_t      state;
    logic [31:0] addr;
    logic [19:0] rem;
    logic [3:0]  tag;
    logic        eof;
    logic        err_slv;
    logic        err_dec;
    logic [7:0]  arlen_q;
    logic        arvalid_q;
    logic        sts_valid_q;
    logic [7:0]  sts_data_q;

    logic [22:0] cmd_btt;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_tag;
    logic        cmd_eof;
    logic [19:0] cmd_beats;
    logic        cmd_illegal;
    logic        r_beat;
    logic [31:0] addr_next;
    logic [19:0] rem_next;
    logic        nxt_slv;
    logic        nxt_dec;
    logic        unused_cmd_bits;

    assign cmd_btt     = s_axis_cmd_tdata[22:0];
    assign cmd_eof     = s_axis_cmd_tdata[30];
    assign cmd_addr    = s_axis_cmd_tdata[63:32];
    assign cmd_tag     = s_axis_cmd_tdata[67:64];
    assign cmd_beats   = cmd_btt[22:3];
    assign cmd_illegal = (cmd_btt == 23'd0) || (cmd_btt[2:0] != 3'd0) || (cmd_addr[2:0] != 3'd0);
    // Only INCR bursts are issued, so the type bit is not used.
    assign unused_cmd_bits = ^{s_axis_cmd_tdata[71:68], s_axis_cmd_tdata[31], s_axis_cmd_tdata[29:23]};

    assign r_beat    = m_axi_rvalid && m_axi_rready;
    assign addr_next = addr + 32'd8;
    assign rem_next  = rem - 20'd1;
    // DECERR for 2'b11, any other non-OKAY response counts as a slave error.
    assign nxt_slv   = err_slv || (r_beat && (m_axi_rresp == 2'b10 || m_axi_rresp == 2'b01));
    assign nxt_dec   = err_dec || (r_beat && (m_axi_rresp == 2'b11));

    function automatic logic [7:0] burst_arlen(input logic [11:0] addr_lo, input logic [19:0] beats);
        logic [12:0] to_4k;
        logic [19:0] len;
        to_4k = (13'd4096 - {1'b0, addr_lo}) >> 3;
        len   = beats;
        if (len > 20'(MAX_BURST)) len = 20'(MAX_BURST);
        if (len > {7'd0, to_4k}) len = {7'd0, to_4k};
        return 8'(len - 20'd1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            rem         <= '0;
            tag         <= '0;
            eof         <= 1'b0;
            err_slv     <= 1'b0;
            err_dec     <= 1'b0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            sts_valid_q <= 1'b0;
            sts_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_cmd_tvalid) begin
                        tag  <= cmd_tag;
                        eof  <= cmd_eof;
                        addr <= cmd_addr;
                        rem  <= cmd_beats;
                        if (cmd_illegal) begin
                            sts_data_q  <= {4'b0001, cmd_tag};
                            sts_valid_q <= 1'b1;
                            state       <= STS;
                        end else begin
                            arlen_q   <= burst_arlen(cmd_addr[11:0], cmd_beats);
                            arvalid_q <= 1'b1;
                            state     <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (r_beat) begin
                        addr    <= addr_next;
                        rem     <= rem_next;
                        err_slv <= nxt_slv;
                        err_dec <= nxt_dec;
                        if (m_axi_rlast) begin
                            if (rem_next != 20'd0) begin
                                arlen_q   <= burst_arlen(addr_next[11:0], rem_next);
                                arvalid_q <= 1'b1;
                                state     <= ADDR;
                            end else begin
                                sts_data_q  <= {~(nxt_slv || nxt_dec), nxt_slv, nxt_dec, 1'b0, tag};
                                sts_valid_q <= 1'b1;
                                state       <= STS;
                            end
                        end
                    end
                end
                STS: begin
                    if (m_axis_sts_tready) begin
                        sts_valid_q <= 1'b0;
                        err_slv     <= 1'b0;
                        err_dec     <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated with rst_n so the command port reads 0 while reset is held.
    assign s_axis_cmd_tready = rst_n && (state == IDLE);

    assign m_axi_arid    = ARID;
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;

    assign m_axi_rready  = m_axis_tready && (state == DATA);
    assign m_axis_tvalid = m_axi_rvalid && (state == DATA);
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tkeep  = 8'hFF;
    assign m_axis_tlast  = (state == DATA) && eof && (rem == 20'd1);

    assign m_axis_sts_tdata  = sts_data_q;
    assign m_axis_sts_tvalid = sts_valid_q;
    assign m_axis_sts_tkeep  = 1'b1;
    assign m_axis_sts_tlast  = 1'b1;

    assign dbg_state = state;

endmodule

// File: tb/tb_mm2s_cmd_engine.sv
// Bench for mm2s_cmd_engine: random AXI read slave and stream/status sinks, checked
// against a model that derives bursts, beats and status directly from the command.
`timescale 1ns/1ps
module tb_mm2s_cmd_engine;

    localparam int         MAX_BURST = 16;
    localparam logic [3:0] ARID      = 4'h9;

    logic        clk;
    logic        rst_n;
    logic        s_axis_cmd_tvalid;
    logic        s_axis_cmd_tready;
    logic [71:0] s_axis_cmd_tdata;
    logic [3:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_sts_tdata;
    logic        m_axis_sts_tvalid;
    logic        m_axis_sts_tkeep;
    logic        m_axis_sts_tlast;
    logic        m_axis_sts_tready;
    logic [1:0]  dbg_state;

    mm2s_cmd_engine #(.MAX_BURST(MAX_BURST), .ARID(ARID)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_cmd_tvalid (s_axis_cmd_tvalid),
        .s_axis_cmd_tready (s_axis_cmd_tready),
        .s_axis_cmd_tdata  (s_axis_cmd_tdata),
        .m_axi_arid        (m_axi_arid),
        .m_axi_araddr      (m_axi_araddr),
        .m_axi_arlen       (m_axi_arlen),
        .m_axi_arsize      (m_axi_arsize),
        .m_axi_arburst     (m_axi_arburst),
        .m_axi_arvalid     (m_axi_arvalid),
        .m_axi_arready     (m_axi_arready),
        .m_axi_rdata       (m_axi_rdata),
        .m_axi_rresp       (m_axi_rresp),
        .m_axi_rlast       (m_axi_rlast),
        .m_axi_rvalid      (m_axi_rvalid),
        .m_axi_rready      (m_axi_rready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_sts_tdata  (m_axis_sts_tdata),
        .m_axis_sts_tvalid (m_axis_sts_tvalid),
        .m_axis_sts_tkeep  (m_axis_sts_tkeep),
        .m_axis_sts_tlast  (m_axis_sts_tlast),
        .m_axis_sts_tready (m_axis_sts_tready),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];
    logic [64:0] exp_q[$];          // {tlast, tdata} per stream beat
    logic [7:0]  exp_sts;
    int          cmd_total;
    int          cmd_rbeats;
    int          cmd_obeats;
    bit          cmd_eof;
    int          err_beat;
    logic [1:0]  err_code;
    bit          sts_seen;
    int          tready_mode;       // 0 random, 1 toggle

    task automatic plan_cmd(input logic [31:0] saddr, input int btt, input bit eof,
                            input logic [3:0] tag, input int eb, input logic [1:0] ec);
        int     rem;
        int     len;
        int     to4k;
        longint a;
        exp_addr_q.delete();
        exp_len_q.delete();
        exp_q.delete();
        cmd_eof    = eof;
        cmd_rbeats = 0;
        cmd_obeats = 0;
        err_beat   = eb;
        err_code   = ec;
        sts_seen   = 0;
        if (btt == 0 || (btt % 8) != 0 || (saddr % 8) != 0) begin
            cmd_total = 0;
            exp_sts   = {4'h1, tag};
        end else begin
            cmd_total = btt / 8;
            rem = cmd_total;
            a   = longint'(saddr);
            while (rem > 0) begin
                to4k = int'((4096 - (a % 4096)) / 8);
                len  = rem;
                if (len > MAX_BURST) len = MAX_BURST;
                if (len > to4k) len = to4k;
                exp_addr_q.push_back(32'(a));
                exp_len_q.push_back(8'(len - 1));
                a   += longint'(len * 8);
                rem -= len;
            end
            if (eb >= 0 && eb < cmd_total && ec == 2'b10)      exp_sts = {4'h4, tag};
            else if (eb >= 0 && eb < cmd_total && ec == 2'b11) exp_sts = {4'h2, tag};
            else                                               exp_sts = {4'h8, tag};
        end
    endtask

    // ---------------- AXI slave + sinks ----------------
    bit          r_active;
    bit          r_pending;
    int          r_left;
    bit          ar_wait;
    logic [31:0] ar_addr_prev;
    logic [7:0]  ar_len_prev;

    task automatic monitor();
        logic        r_fire;
        logic        s_fire;
        logic [64:0] e;
        check("rready_mirror", m_axi_rready, r_active && m_axis_tready);
        check("tvalid_gate", m_axis_tvalid, r_active && m_axi_rvalid);
        if (r_active) check("ar_one_outstanding", m_axi_arvalid, 1'b0);

        r_fire = m_axi_rvalid && m_axi_rready;
        s_fire = m_axis_tvalid && m_axis_tready;
        check("beat_pair", s_fire, r_fire);
        if (r_fire) begin
            exp_q.push_back({cmd_eof && (cmd_rbeats == cmd_total - 1), m_axi_rdata});
            cmd_rbeats++;
            r_pending = 0;
            r_left--;
            if (r_left <= 0) r_active = 0;
        end
        if (s_fire) begin
            check("stream_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tdata", m_axis_tdata, e[63:0]);
                check("tlast", m_axis_tlast, e[64]);
                check("tkeep", m_axis_tkeep, 8'hFF);
            end
            cmd_obeats++;
        end

        if (m_axis_sts_tvalid && m_axis_sts_tready) begin
            check("sts_data", m_axis_sts_tdata, exp_sts);
            check("sts_keep_last", {m_axis_sts_tkeep, m_axis_sts_tlast}, 2'b11);
            check("sts_beats", cmd_obeats, cmd_total);
            check("sts_bursts_left", exp_addr_q.size(), 0);
            sts_seen = 1;
        end

        if (ar_wait) begin
            check("ar_hold", m_axi_arvalid, 1'b1);
            check("ar_stable", {m_axi_araddr, m_axi_arlen}, {ar_addr_prev, ar_len_prev});
        end
        if (m_axi_arvalid && m_axi_arready) begin
            check("ar_pending", exp_addr_q.size() > 0, 1'b1);
            if (exp_addr_q.size() > 0) begin
                check("araddr", m_axi_araddr, exp_addr_q.pop_front());
                check("arlen", m_axi_arlen, exp_len_q.pop_front());
            end
            check("ar_fixed", {m_axi_arid, m_axi_arsize, m_axi_arburst}, {ARID, 3'b011, 2'b01});
            r_active = 1;
            r_left   = int'(m_axi_arlen) + 1;
            ar_wait  = 0;
        end else if (m_axi_arvalid) begin
            ar_wait      = 1;
            ar_addr_prev = m_axi_araddr;
            ar_len_prev  = m_axi_arlen;
        end else begin
            ar_wait = 0;
        end
    endtask

    task automatic drive();
        m_axi_arready     = ($urandom_range(0, 3) != 0);
        m_axis_sts_tready = ($urandom_range(0, 2) != 0);
        if (tready_mode == 1) m_axis_tready = ~m_axis_tready;
        else                  m_axis_tready = ($urandom_range(0, 3) != 0);
        if (r_active) begin
            if (!r_pending) begin
                if ($urandom_range(0, 3) != 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = {$urandom, $urandom};
                    m_axi_rlast  = (r_left == 1);
                    m_axi_rresp  = (cmd_rbeats == err_beat) ? err_code : 2'b00;
                    r_pending    = 1;
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    m_axi_rresp  = 2'b00;
                end
            end
        end else begin
            // Stray beats with an error response outside a burst must be ignored.
            r_pending    = 0;
            m_axi_rvalid = ($urandom_range(0, 7) == 0);
            m_axi_rdata  = {$urandom, $urandom};
            m_axi_rlast  = m_axi_rvalid;
            m_axi_rresp  = 2'b11;
        end
    endtask

    initial begin
        m_axi_arready     = 1'b0;
        m_axi_rvalid      = 1'b0;
        m_axi_rdata       = '0;
        m_axi_rresp       = 2'b00;
        m_axi_rlast       = 1'b0;
        m_axis_tready     = 1'b0;
        m_axis_sts_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                r_active  = 0;
                r_pending = 0;
                ar_wait   = 0;
            end else begin
                monitor();
            end
            @(posedge clk);
            #1;
            drive();
        end
    end

    // ---------------- command driver ----------------
    task automatic issue_cmd(input logic [31:0] saddr, input int btt, input bit eof,
                             input logic [3:0] tag, input int eb, input logic [1:0] ec);
        int          n;
        logic [71:0] d;
        @(posedge clk);
        #1;
        plan_cmd(saddr, btt, eof, tag, eb, ec);
        d = {$urandom, $urandom, $urandom};
        d[22:0]  = 23'(btt);
        d[30]    = eof;
        d[63:32] = saddr;
        d[67:64] = tag;
        s_axis_cmd_tdata  = d;
        s_axis_cmd_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axis_cmd_tready && n < 200);
        check("cmd_accept", s_axis_cmd_tready, 1'b1);
        @(posedge clk);
        #1;
        s_axis_cmd_tvalid = 1'b0;
    endtask

    task automatic wait_sts(input int limit);
        int n;
        n = 0;
        while (!sts_seen && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("sts_arrived", sts_seen, 1'b1);
    endtask

    task automatic run_cmd(input logic [31:0] saddr, input int btt, input bit eof,
                           input logic [3:0] tag, input int eb, input logic [1:0] ec);
        issue_cmd(saddr, btt, eof, tag, eb, ec);
        wait_sts(5000);
    endtask

    task automatic run_illegal(input logic [31:0] saddr, input int btt, input logic [3:0] tag);
        int n;
        issue_cmd(saddr, btt, 1'b1, tag, -1, 2'b00);
        n = 0;
        while (!m_axis_sts_tvalid && n < 2) begin
            @(negedge clk);
            n++;
        end
        check("interr_latency", m_axis_sts_tvalid, 1'b1);
        wait_sts(100);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          n;
        int          beats;
        int          btt;
        int          eb;
        logic [31:0] saddr;
        logic [1:0]  ec;

        rst_n             = 1'b0;
        s_axis_cmd_tvalid = 1'b0;
        s_axis_cmd_tdata  = '0;
        tready_mode       = 0;
        cmd_total         = 0;
        exp_sts           = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_tready", s_axis_cmd_tready, 1'b0);
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_araddr_arlen", {m_axi_araddr, m_axi_arlen}, 40'd0);
        check("rst_sts", {m_axis_sts_tvalid, m_axis_sts_tdata}, 9'd0);
        check("rst_arid", m_axi_arid, ARID);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("cmd_tready_after_reset", s_axis_cmd_tready, 1'b1);

        // 2KB from 0: sixteen full bursts, tlast on the final beat
        run_cmd(32'h0, 2048, 1'b1, 4'h5, -1, 2'b00);
        // straddles a 4KB boundary; EOF=0 so no tlast
        run_cmd(32'hFF8, 32, 1'b0, 4'h1, -1, 2'b00);
        // illegal commands
        run_illegal(32'h100, 0, 4'h3);
        run_illegal(32'h4, 64, 4'h3);
        run_illegal(32'h200, 12, 4'hC);
        // read response errors, stream still completes
        run_cmd(32'h500, 64, 1'b1, 4'h2, 2, 2'b10);
        run_cmd(32'h600, 40, 1'b1, 4'h6, 4, 2'b11);
        // stream backpressure toggling every cycle
        tready_mode = 1;
        run_cmd(32'h800, 128, 1'b1, 4'h4, -1, 2'b00);
        tready_mode = 0;

        // reset in the middle of a 16-beat command
        issue_cmd(32'h2000, 128, 1'b1, 4'h7, -1, 2'b00);
        n = 0;
        while (cmd_obeats < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_beat5", cmd_obeats >= 5, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", {m_axi_arvalid, m_axis_tvalid, m_axis_sts_tvalid}, 3'b000);
        exp_addr_q.delete();
        exp_len_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("cmd_tready_after_abort", s_axis_cmd_tready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("no_sts_after_abort", m_axis_sts_tvalid, 1'b0);
        end
        run_cmd(32'h3000, 8, 1'b1, 4'hA, -1, 2'b00);

        // randomized commands, biased toward 4KB boundaries
        for (int i = 0; i < 25; i++) begin
            beats = $urandom_range(1, 64);
            saddr = 32'($urandom_range(0, 15) * 4096 + 4096 - 8 * $urandom_range(1, 40));
            btt   = beats * 8;
            if ($urandom_range(0, 7) == 0) saddr = saddr + 32'($urandom_range(1, 7));
            if ($urandom_range(0, 9) == 0) btt = btt + $urandom_range(1, 7);
            eb = -1;
            ec = 2'b00;
            if ($urandom_range(0, 2) == 0) begin
                eb = $urandom_range(0, beats - 1);
                ec = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
            end
            run_cmd(saddr, btt, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), eb, ec);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mm2s_cmd_engine.md
MM2S_CMD_ENGINE -- requirements
Module: mm2s_cmd_engine

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, giving the maximum beats per AXI read burst (legal range 1..256).
REQ-002 SHALL have parameter ARID, default 4'd0, driven constant on m_axi_arid.
REQ-003 SHALL run on one clock, with reset asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 s_axis_cmd_tvalid/tready  in/out  1/1  command handshake.
REQ-007 s_axis_cmd_tdata  in  72  DataMover command: [22:0] BTT bytes, [23] type, [30] EOF, [63:32] SADDR, [67:64] TAG, others ignored.
REQ-008 m_axi_arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI4 read address channel.
REQ-009 m_axi_arready  in  1  read address accept.
REQ-010 m_axi_rdata/rresp/rlast/rvalid  in  64/2/1/1  AXI4 read data channel.
REQ-011 m_axi_rready  out  1  read data accept.
REQ-012 m_axis_tdata/tkeep/tlast/tvalid  out  64/8/1/1  output data stream.
REQ-013 m_axis_tready  in  1  stream backpressure.
REQ-014 m_axis_sts_tdata/tvalid/tkeep/tlast  out  8/1/1/1  status; tkeep and tlast tied 1.
REQ-015 m_axis_sts_tready  in  1  status accept.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR, DATA and STS, plus the transitions in REQ-017 to REQ-025.
REQ-017 IDLE: s_axis_cmd_tready SHALL be 1; on command handshake, latch address, beat count BTT>>3, TAG and EOF.
REQ-018 A command SHALL be illegal when BTT==0, BTT[2:0]!=0, or SADDR[2:0]!=0.
REQ-019 An illegal command SHALL go IDLE->STS with status INTERR, issuing no AR transaction.
REQ-020 A legal command SHALL go IDLE->ADDR.
REQ-021 ADDR: arlen+1 SHALL equal min(remaining beats, MAX_BURST, beats to the next 4KB boundary); arsize=3'b011, arburst=2'b01.
REQ-022 ADDR: arvalid SHALL be held with stable fields until arready; on handshake go to DATA.
REQ-023 Only one burst SHALL be outstanding; no new AR until rlast of the current burst is accepted.
REQ-024 DATA: each rvalid&rready beat SHALL decrement remaining beats and advance the address by 8.
REQ-025 On rlast: remaining beats nonzero -> ADDR; zero -> STS.
REQ-026 Data path SHALL be combinational pass-through: m_axis_tvalid=rvalid&&(state==DATA); m_axi_rready=m_axis_tready&&(state==DATA); tdata=rdata; tkeep=8'hFF.
REQ-027 m_axis_tlast SHALL assert only on the final beat of the command, and only when EOF=1.
REQ-028 rresp!=OKAY on any beat SHALL set sticky SLVERR (2'b10) or DECERR (2'b11); the transfer still completes all beats.
REQ-029 Status byte SHALL be [7] OKAY (no error flag set), [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG.
REQ-030 STS: sts_tvalid SHALL be held until sts_tready, then clear flags and go to IDLE.
REQ-031 Beat counter SHALL be 20 bits; the 4KB calc SHALL use (4096-araddr[11:0])>>3.
REQ-032 An rvalid outside DATA SHALL be ignored, with rready=0.

Reset
REQ-033 On rst_n low, all outputs SHALL be 0 (except constants), state IDLE, and error flags cleared, asynchronously.
REQ-034 Reset mid-burst SHALL abandon the command without emitting status; after release, cmd_tready=1 in the first cycle.

Verification
REQ-035 SADDR=0, BTT=2048, EOF=1, TAG=5 -> 16 bursts arlen=15 at 0x0,0x80,...,0x780; 256 beats; tlast on beat 256 only; status 8'h85.
REQ-036 SADDR=0xFF8, BTT=32, TAG=1 -> AR arlen=0 @0xFF8, then arlen=2 @0x1000; 4 beats; status 8'h81.
REQ-037 BTT=0 or SADDR=0x4, TAG=3 -> no arvalid; status 8'h13 within 2 cycles.
REQ-038 BTT=64, rresp=2'b10 on beat 3 -> all 8 beats streamed; status 8'h40|TAG.
REQ-039 BTT=128 with m_axis_tready toggling 1/0 every cycle -> rready mirrors tready; data order preserved; 16 beats, single tlast.
REQ-040 rst_n asserted at beat 5 of a 16-beat command -> arvalid/tvalid/sts_tvalid drop immediately; next command BTT=8 -> one beat, status 8'h80|TAG.
